// File: rtl/ctrl_pkg.sv
// Shared opcode constants, state encoding and instruction-class decode
// for the single-bus processor control unit.
package ctrl_pkg;
  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_BR   = 5'b10010;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam logic [1:0] ALU_ADD = 2'd0;
  localparam logic [1:0] ALU_SUB = 2'd1;
  localparam logic [1:0] ALU_AND = 2'd2;
  localparam logic [1:0] ALU_OR  = 2'd3;

  typedef enum logic [3:0] {RST, F0, F1, F2, T3, T4, T5, T6, T7, HALT} state_t;

  typedef enum logic [2:0] {C_ALU, C_IMM, C_LDI, C_LD, C_ST, C_BR, C_NOP, C_HALT} iclass_t;

  // Unknown opcodes fall into the halt class.
  function automatic iclass_t decode_class(input logic [4:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR: decode_class = C_ALU;
      OP_ADDI, OP_ANDI, OP_ORI:      decode_class = C_IMM;
      OP_LDI:                        decode_class = C_LDI;
      OP_LD:                         decode_class = C_LD;
      OP_ST:                         decode_class = C_ST;
      OP_BR:                         decode_class = C_BR;
      OP_NOP:                        decode_class = C_NOP;
      default:                       decode_class = C_HALT;
    endcase
  endfunction

  function automatic logic [1:0] alu_func(input logic [4:0] op);
    case (op)
      OP_SUB:          alu_func = ALU_SUB;
      OP_AND, OP_ANDI: alu_func = ALU_AND;
      OP_OR, OP_ORI:   alu_func = ALU_OR;
      default:         alu_func = ALU_ADD;
    endcase
  endfunction
endpackage

// File: rtl/mem_wait_timer.sv
// Counts stalled cycles in a memory wait state and flags the timeout cycle.
module mem_wait_timer #(
  parameter int WAIT_LIMIT = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  input  logic ready,
  output logic expired
);
  localparam int CW = (WAIT_LIMIT < 1) ? 1 : $clog2(WAIT_LIMIT + 1);

  logic [CW-1:0] count;

  always_ff @(posedge clock) begin
    if (reset || clear) count <= '0;
    else if (enable && !ready && count != CW'(WAIT_LIMIT)) count <= count + 1'b1;
  end

  // A ready in the limit cycle takes priority over the timeout.
  if (WAIT_LIMIT == 0) begin : g_off
    assign expired = 1'b0;
  end else begin : g_on
    assign expired = enable && !ready && (count == CW'(WAIT_LIMIT));
  end
endmodule

// File: rtl/control_sequencer.sv
// Hardwired fetch/execute sequencer for the single-bus processor; Moore
// strobes decoded from the state and the instruction register.
module control_sequencer
  import ctrl_pkg::*;
#(
  parameter int WAIT_LIMIT = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] ir,
  input  logic        con_ff,
  input  logic        mem_ready,
  output logic        pc_out,
  output logic        pc_in,
  output logic        inc_pc,
  output logic        mar_in,
  output logic        mdr_in,
  output logic        mdr_out,
  output logic        ir_in,
  output logic        y_in,
  output logic        z_in,
  output logic        zlow_out,
  output logic        c_out,
  output logic        con_in,
  output logic        read,
  output logic        write,
  output logic        gra,
  output logic        grb,
  output logic        grc,
  output logic        r_in,
  output logic        r_out,
  output logic        ba_out,
  output logic [1:0]  alu_op,
  output logic        run,
  output logic        fault
);
  state_t  state;
  iclass_t cls;
  logic    in_wait, expired;
  logic    unused_ir;

  assign cls       = decode_class(ir[31:27]);
  assign unused_ir = ^ir[26:0];
  assign in_wait   = (state == F1) || (state == T6 && cls == C_LD) || (state == T7 && cls == C_ST);

  mem_wait_timer #(.WAIT_LIMIT(WAIT_LIMIT)) u_timer (
    .clock  (clock),
    .reset  (reset),
    .clear  (!in_wait),
    .enable (in_wait),
    .ready  (mem_ready),
    .expired(expired)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= RST;
      fault <= 1'b0;
    end else begin
      case (state)
        RST: state <= F0;
        F0:  state <= F1;
        F1: begin
          if (mem_ready) state <= F2;
          else if (expired) begin state <= HALT; fault <= 1'b1; end
        end
        F2: state <= T3;
        T3: begin
          if (cls == C_NOP) state <= F0;
          else if (cls == C_HALT) state <= HALT;
          else state <= T4;
        end
        T4: state <= T5;
        T5: state <= (cls == C_LD || cls == C_ST || cls == C_BR) ? T6 : F0;
        T6: begin
          if (cls != C_LD || mem_ready) state <= (cls == C_BR) ? F0 : T7;
          else if (expired) begin state <= HALT; fault <= 1'b1; end
        end
        T7: begin
          if (cls != C_ST || mem_ready) state <= F0;
          else if (expired) begin state <= HALT; fault <= 1'b1; end
        end
        default: state <= HALT;
      endcase
    end
  end

  // ir is read combinationally because ir_in in F2 only lands at the T3 edge.
  always_comb begin
    pc_out = 1'b0; pc_in = 1'b0; inc_pc = 1'b0; mar_in = 1'b0; mdr_in = 1'b0;
    mdr_out = 1'b0; ir_in = 1'b0; y_in = 1'b0; z_in = 1'b0; zlow_out = 1'b0;
    c_out = 1'b0; con_in = 1'b0; read = 1'b0; write = 1'b0;
    gra = 1'b0; grb = 1'b0; grc = 1'b0; r_in = 1'b0; r_out = 1'b0; ba_out = 1'b0;
    alu_op = ALU_ADD;
    run = (state != RST) && (state != HALT);
    case (state)
      F0: begin pc_out = 1'b1; mar_in = 1'b1; inc_pc = 1'b1; z_in = 1'b1; end
      F1: begin zlow_out = 1'b1; pc_in = 1'b1; read = 1'b1; mdr_in = 1'b1; end
      F2: begin mdr_out = 1'b1; ir_in = 1'b1; end
      T3: case (cls)
        C_ALU, C_IMM:      begin grb = 1'b1; r_out = 1'b1; y_in = 1'b1; end
        C_LDI, C_LD, C_ST: begin grb = 1'b1; ba_out = 1'b1; y_in = 1'b1; end
        C_BR:              begin gra = 1'b1; r_out = 1'b1; con_in = 1'b1; end
        default: ;
      endcase
      T4: case (cls)
        C_ALU:             begin grc = 1'b1; r_out = 1'b1; z_in = 1'b1; alu_op = alu_func(ir[31:27]); end
        C_IMM:             begin c_out = 1'b1; z_in = 1'b1; alu_op = alu_func(ir[31:27]); end
        C_LDI, C_LD, C_ST: begin c_out = 1'b1; z_in = 1'b1; end
        C_BR:              begin pc_out = 1'b1; y_in = 1'b1; end
        default: ;
      endcase
      T5: case (cls)
        C_ALU, C_IMM, C_LDI: begin zlow_out = 1'b1; gra = 1'b1; r_in = 1'b1; end
        C_LD, C_ST:          begin zlow_out = 1'b1; mar_in = 1'b1; end
        C_BR:                begin c_out = 1'b1; z_in = 1'b1; end
        default: ;
      endcase
      T6: case (cls)
        C_LD: begin read = 1'b1; mdr_in = 1'b1; end
        C_ST: begin gra = 1'b1; r_out = 1'b1; mdr_in = 1'b1; end
        C_BR: begin zlow_out = con_ff; pc_in = con_ff; end
        default: ;
      endcase
      T7: case (cls)
        C_LD: begin mdr_out = 1'b1; gra = 1'b1; r_in = 1'b1; end
        C_ST: write = 1'b1;
        default: ;
      endcase
      default: ;
    endcase
  end
endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: a trace model expands each instruction into
// its expected per-cycle strobe rows, which are then replayed against the DUT.
module tb_control_sequencer;
  localparam int WL = 4;

  localparam logic [20:0] PC_OUT = 21'h1, PC_IN = 21'h2, INC_PC = 21'h4, MAR_IN = 21'h8;
  localparam logic [20:0] MDR_IN = 21'h10, MDR_OUT = 21'h20, IR_IN = 21'h40, Y_IN = 21'h80;
  localparam logic [20:0] Z_IN = 21'h100, ZLOW_OUT = 21'h200, C_OUT = 21'h400, CON_IN = 21'h800;
  localparam logic [20:0] READ = 21'h1000, WRITE = 21'h2000, GRA = 21'h4000, GRB = 21'h8000;
  localparam logic [20:0] GRC = 21'h10000, R_IN = 21'h20000, R_OUT = 21'h40000, BA_OUT = 21'h80000;
  localparam logic [20:0] RUN = 21'h100000;

  logic clock, reset, con_ff, mem_ready;
  logic [31:0] ir_reg = '0;
  logic [31:0] fetch_word = '0;
  logic pc_out, pc_in, inc_pc, mar_in, mdr_in, mdr_out, ir_in, y_in, z_in, zlow_out, c_out, con_in;
  logic read, write, gra, grb, grc, r_in, r_out, ba_out, run, fault;
  logic [1:0] alu_op;
  logic [20:0] act;

  control_sequencer #(.WAIT_LIMIT(WL)) dut (
    .clock(clock), .reset(reset), .ir(ir_reg), .con_ff(con_ff), .mem_ready(mem_ready),
    .pc_out(pc_out), .pc_in(pc_in), .inc_pc(inc_pc), .mar_in(mar_in), .mdr_in(mdr_in),
    .mdr_out(mdr_out), .ir_in(ir_in), .y_in(y_in), .z_in(z_in), .zlow_out(zlow_out),
    .c_out(c_out), .con_in(con_in), .read(read), .write(write), .gra(gra), .grb(grb),
    .grc(grc), .r_in(r_in), .r_out(r_out), .ba_out(ba_out), .alu_op(alu_op), .run(run),
    .fault(fault)
  );

  assign act = {run, ba_out, r_out, r_in, grc, grb, gra, write, read, con_in, c_out, zlow_out,
                z_in, y_in, ir_in, mdr_out, mdr_in, mar_in, inc_pc, pc_in, pc_out};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Instruction memory stand-in: ir loads the fetched word when ir_in is strobed.
  always @(posedge clock) if (ir_in) ir_reg <= fetch_word;

  typedef struct {
    logic [20:0] s;
    logic [1:0]  alu;
    logic        fault;
    logic        rdy;
    logic        con;
    logic [31:0] word;
  } row_t;

  row_t exp_q[$];
  int checks = 0, errors = 0;
  logic model_fault = 1'b0;
  logic cur_con = 1'b0;
  logic [31:0] cur_word = '0;

  task automatic push(input logic [20:0] s, input logic [1:0] alu, input logic rdy);
    row_t r;
    r.s = s; r.alu = alu; r.fault = model_fault; r.rdy = rdy; r.con = cur_con; r.word = cur_word;
    exp_q.push_back(r);
  endtask

  task automatic push_halt();
    repeat (3) push(21'h0, 2'd0, 1'b0);
  endtask

  // n stalled cycles then completion, or a timeout after WL+1 stalled cycles.
  task automatic wait_rows(input logic [20:0] s, input int n, output bit ok);
    if (WL != 0 && n > WL) begin
      repeat (WL + 1) push(s, 2'd0, 1'b0);
      model_fault = 1'b1;
      push_halt();
      ok = 1'b0;
    end else begin
      repeat (n) push(s, 2'd0, 1'b0);
      push(s, 2'd0, 1'b1);
      ok = 1'b1;
    end
  endtask

  task automatic gen(input logic [31:0] w, input logic c, input int wf, input int wm, output bit halted);
    logic [4:0] op;
    bit ok;
    op = w[31:27]; cur_word = w; cur_con = c; halted = 1'b0;
    push(RUN | PC_OUT | MAR_IN | INC_PC | Z_IN, 2'd0, 1'b1);
    wait_rows(RUN | ZLOW_OUT | PC_IN | READ | MDR_IN, wf, ok);
    if (!ok) begin halted = 1'b1; return; end
    push(RUN | MDR_OUT | IR_IN, 2'd0, 1'b1);
    case (op)
      5'b00011, 5'b00100, 5'b00101, 5'b00110: begin
        push(RUN | GRB | R_OUT | Y_IN, 2'd0, 1'b1);
        push(RUN | GRC | R_OUT | Z_IN, (op == 5'b00011) ? 2'd0 : (op == 5'b00100) ? 2'd1 :
             (op == 5'b00101) ? 2'd2 : 2'd3, 1'b1);
        push(RUN | ZLOW_OUT | GRA | R_IN, 2'd0, 1'b1);
      end
      5'b01100, 5'b01101, 5'b01110: begin
        push(RUN | GRB | R_OUT | Y_IN, 2'd0, 1'b1);
        push(RUN | C_OUT | Z_IN, (op == 5'b01100) ? 2'd0 : (op == 5'b01101) ? 2'd2 : 2'd3, 1'b1);
        push(RUN | ZLOW_OUT | GRA | R_IN, 2'd0, 1'b1);
      end
      5'b00001: begin
        push(RUN | GRB | BA_OUT | Y_IN, 2'd0, 1'b1);
        push(RUN | C_OUT | Z_IN, 2'd0, 1'b1);
        push(RUN | ZLOW_OUT | GRA | R_IN, 2'd0, 1'b1);
      end
      5'b00000, 5'b00010: begin
        push(RUN | GRB | BA_OUT | Y_IN, 2'd0, 1'b1);
        push(RUN | C_OUT | Z_IN, 2'd0, 1'b1);
        push(RUN | ZLOW_OUT | MAR_IN, 2'd0, 1'b1);
        if (op == 5'b00000) begin
          wait_rows(RUN | READ | MDR_IN, wm, ok);
          if (ok) push(RUN | MDR_OUT | GRA | R_IN, 2'd0, 1'b1);
        end else begin
          push(RUN | GRA | R_OUT | MDR_IN, 2'd0, 1'b1);
          wait_rows(RUN | WRITE, wm, ok);
        end
        halted = !ok;
      end
      5'b10010: begin
        push(RUN | GRA | R_OUT | CON_IN, 2'd0, 1'b1);
        push(RUN | PC_OUT | Y_IN, 2'd0, 1'b1);
        push(RUN | C_OUT | Z_IN, 2'd0, 1'b1);
        push(c ? (RUN | ZLOW_OUT | PC_IN) : RUN, 2'd0, 1'b1);
      end
      5'b11010: push(RUN, 2'd0, 1'b1);
      default: begin
        push(RUN, 2'd0, 1'b1);
        push_halt();
        halted = 1'b1;
      end
    endcase
  endtask

  task automatic drive_row(input row_t r, output logic [20:0] s, output logic [1:0] a, output logic f);
    @(negedge clock);
    mem_ready = r.rdy; con_ff = r.con; fetch_word = r.word;
    #1;
    s = act; a = alu_op; f = fault;
  endtask

  task automatic do_reset();
    @(negedge clock); reset = 1'b1; mem_ready = 1'b0;
    @(negedge clock); reset = 1'b0;
    model_fault = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; mem_ready = 1'b0; con_ff = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock); #1;
    checks++;
    if ({act, alu_op, fault} !== 24'h0) begin
      errors++;
      $display("FAIL reset_state got s=%h alu=%0d fault=%b want all zero", act, alu_op, fault);
    end
    reset = 1'b0;
    model_fault = 1'b0;
  endtask

  task automatic test_alu();
    row_t r; logic [20:0] s; logic [1:0] a; logic f; bit h; int n = 0;
    gen(32'h19880000, 1'b0, 0, 0, h);
    gen(32'h68880005, 1'b0, 1, 0, h);
    gen(32'h70880006, 1'b0, 0, 0, h);
    gen(32'h08000010, 1'b0, 0, 0, h);
    gen(32'h2A000000, 1'b0, 2, 0, h);
    while (exp_q.size() > 0) begin
      r = exp_q.pop_front(); drive_row(r, s, a, f); checks++;
      if ({s, a, f} !== {r.s, r.alu, r.fault}) begin
        errors++;
        $display("FAIL alu row %0d got s=%h alu=%0d fault=%b want s=%h alu=%0d fault=%b", n, s, a, f, r.s, r.alu, r.fault);
      end
      n++;
    end
  endtask

  task automatic test_ld_st_wait();
    row_t r; logic [20:0] s; logic [1:0] a; logic f; bit h; int n = 0;
    do_reset();
    gen(32'h01000008, 1'b0, 0, 3, h);
    gen(32'h11800004, 1'b0, 1, 2, h);
    gen(32'h01000008, 1'b0, 0, WL, h);
    while (exp_q.size() > 0) begin
      r = exp_q.pop_front(); drive_row(r, s, a, f); checks++;
      if ({s, a, f} !== {r.s, r.alu, r.fault}) begin
        errors++;
        $display("FAIL ld_st row %0d got s=%h alu=%0d fault=%b want s=%h alu=%0d fault=%b", n, s, a, f, r.s, r.alu, r.fault);
      end
      n++;
    end
  endtask

  task automatic test_branch();
    row_t r; logic [20:0] s; logic [1:0] a; logic f; bit h; int n = 0;
    do_reset();
    gen(32'h90800000, 1'b0, 0, 0, h);
    gen(32'h90800000, 1'b1, 0, 0, h);
    gen(32'hD0000000, 1'b1, 0, 0, h);
    while (exp_q.size() > 0) begin
      r = exp_q.pop_front(); drive_row(r, s, a, f); checks++;
      if ({s, a, f} !== {r.s, r.alu, r.fault}) begin
        errors++;
        $display("FAIL branch row %0d got s=%h alu=%0d fault=%b want s=%h alu=%0d fault=%b", n, s, a, f, r.s, r.alu, r.fault);
      end
      n++;
    end
  endtask

  task automatic test_timeout();
    row_t r; logic [20:0] s; logic [1:0] a; logic f; bit h; int n = 0;
    do_reset();
    gen(32'hD0000000, 1'b0, WL, 0, h);
    gen(32'h19880000, 1'b0, 40, 0, h);
    while (exp_q.size() > 0) begin
      r = exp_q.pop_front(); drive_row(r, s, a, f); checks++;
      if ({s, a, f} !== {r.s, r.alu, r.fault}) begin
        errors++;
        $display("FAIL timeout row %0d got s=%h alu=%0d fault=%b want s=%h alu=%0d fault=%b", n, s, a, f, r.s, r.alu, r.fault);
      end
      n++;
    end
  endtask

  task automatic test_illegal_abort();
    row_t r; logic [20:0] s; logic [1:0] a; logic f; bit h; int n = 0;
    do_reset();
    gen(32'hF8000000, 1'b0, 0, 0, h);
    while (exp_q.size() > 0) begin
      r = exp_q.pop_front(); drive_row(r, s, a, f); checks++;
      if ({s, a, f} !== {r.s, r.alu, r.fault}) begin
        errors++;
        $display("FAIL illegal row %0d got s=%h alu=%0d fault=%b want s=%h alu=%0d fault=%b", n, s, a, f, r.s, r.alu, r.fault);
      end
      n++;
    end
    // Abort a load stalled in its memory wait, then restart cleanly.
    do_reset();
    gen(32'h01000008, 1'b0, 0, WL + 2, h);
    for (int i = 0; i < 7; i++) begin
      r = exp_q.pop_front(); drive_row(r, s, a, f); checks++;
      if ({s, a, f} !== {r.s, r.alu, r.fault}) begin
        errors++;
        $display("FAIL abort_pre row %0d got s=%h alu=%0d fault=%b want s=%h alu=%0d fault=%b", i, s, a, f, r.s, r.alu, r.fault);
      end
    end
    exp_q.delete();
    @(negedge clock); reset = 1'b1; mem_ready = 1'b0;
    @(negedge clock); #1;
    checks++;
    if ({act, alu_op, fault} !== 24'h0) begin
      errors++;
      $display("FAIL abort_reset got s=%h alu=%0d fault=%b want all zero", act, alu_op, fault);
    end
    reset = 1'b0; model_fault = 1'b0;
    gen(32'hD0000000, 1'b0, 0, 0, h);
    n = 0;
    while (exp_q.size() > 0) begin
      r = exp_q.pop_front(); drive_row(r, s, a, f); checks++;
      if ({s, a, f} !== {r.s, r.alu, r.fault}) begin
        errors++;
        $display("FAIL abort_post row %0d got s=%h alu=%0d fault=%b want s=%h alu=%0d fault=%b", n, s, a, f, r.s, r.alu, r.fault);
      end
      n++;
    end
  endtask

  task automatic test_back_to_back();
    row_t r; logic [20:0] s; logic [1:0] a; logic f; bit h; int n = 0;
    do_reset();
    gen(32'h20888000, 1'b0, 0, 0, h);
    gen(32'hD8000000, 1'b0, 0, 0, h);
    while (exp_q.size() > 0) begin
      r = exp_q.pop_front(); drive_row(r, s, a, f); checks++;
      if ({s, a, f} !== {r.s, r.alu, r.fault}) begin
        errors++;
        $display("FAIL back_to_back row %0d got s=%h alu=%0d fault=%b want s=%h alu=%0d fault=%b", n, s, a, f, r.s, r.alu, r.fault);
      end
      n++;
    end
  endtask

  function automatic int pick_wait();
    int k;
    k = int'($urandom_range(0, 19));
    pick_wait = (k < 16) ? k % 3 : (k < 19) ? WL : WL + 1;
  endfunction

  task automatic test_random();
    row_t r; logic [20:0] s; logic [1:0] a; logic f; bit h; int n = 0;
    logic [4:0] ops [16];
    logic [31:0] rnd;
    ops = '{5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b01100,
            5'b01101, 5'b01110, 5'b10010, 5'b11010, 5'b00011, 5'b10010, 5'b11011, 5'b10111};
    do_reset();
    for (int it = 0; it < 80; it++) begin
      rnd = $urandom();
      gen({ops[$urandom_range(0, 15)], rnd[26:0]}, 1'($urandom_range(0, 1)), pick_wait(), pick_wait(), h);
      if (h || it == 79) begin
        while (exp_q.size() > 0) begin
          r = exp_q.pop_front(); drive_row(r, s, a, f); checks++;
          if ({s, a, f} !== {r.s, r.alu, r.fault}) begin
            errors++;
            $display("FAIL random row %0d got s=%h alu=%0d fault=%b want s=%h alu=%0d fault=%b word=%h", n, s, a, f, r.s, r.alu, r.fault, r.word);
          end
          n++;
        end
        if (h) do_reset();
      end
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_ld_st_wait();
    test_branch();
    test_timeout();
    test_illegal_abort();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Hardwired control unit for the single-bus processor.
- Steps each instruction through fetch and execute microsteps and drives the register select/encode strobes (gra, grb, grc, r_in, r_out, ba_out) plus the bus, ALU and memory strobes.
- Waits on a memory ready handshake and stops in HALT on halt, illegal opcode or memory timeout.

Parameters:
- WAIT_LIMIT, 16: maximum cycles in any memory wait state before a timeout fault; 0 disables the timeout.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- ir  in  32  instruction register contents; opcode ir[31:27]
- con_ff  in  1  branch condition flag
- mem_ready  in  1  memory completes the current Read/Write this cycle
- pc_out, pc_in, inc_pc, mar_in, mdr_in, mdr_out, ir_in, y_in, z_in, zlow_out, c_out, con_in  out  1 each  datapath strobes
- read, write  out  1 each  memory strobes
- gra, grb, grc, r_in, r_out, ba_out  out  1 each  register select/encode controls
- alu_op  out  2  ALU function: 0 ADD, 1 SUB, 2 AND, 3 OR
- run  out  1  high while sequencing
- fault  out  1  sticky memory-timeout flag

Behaviour:
- Reset: while reset=1, state becomes RST, all outputs are 0, and the wait counter is cleared. RST goes to F0 on the next cycle.
- Outputs are Moore: decoded from state and the registered ir only. run=1 in every state except RST and HALT.
- Fetch states:
  - F0: pc_out, mar_in, inc_pc, z_in (alu_op ADD).
  - F1: zlow_out, pc_in, read, mdr_in. Stays in F1 until mem_ready=1.
  - F2: mdr_out, ir_in. Then goes to T3.
- Execute classes (every class returns to F0 after its last step):
  - Register ALU (add 00011, sub 00100, and 00101, or 00110): T3 grb, r_out, y_in; T4 grc, r_out, alu_op, z_in; T5 zlow_out, gra, r_in.
  - Immediate ALU (addi 01100 ADD, andi 01101 AND, ori 01110 OR): T3 grb, r_out, y_in; T4 c_out, alu_op, z_in; T5 zlow_out, gra, r_in.
  - ldi 00001: T3 grb, ba_out, y_in; T4 c_out, ADD, z_in; T5 zlow_out, gra, r_in.
  - ld 00000: T3 to T4 as ldi; T5 zlow_out, mar_in; T6 read, mdr_in, waits for mem_ready; T7 mdr_out, gra, r_in.
  - st 00010: T3 to T5 as ld; T6 gra, r_out, mdr_in; T7 write, waits for mem_ready.
  - br 10010: T3 gra, r_out, con_in; T4 pc_out, y_in; T5 c_out, ADD, z_in; T6 zlow_out, pc_in only if con_ff=1, otherwise no strobes.
  - nop 11010: returns from T3 to F0 with no strobes in T3.
  - halt 11011 and any other opcode: T3 goes to HALT.
- HALT: absorbing until reset; all strobes 0, run=0.
- Memory wait states (F1, ld-T6, st-T7):
  - The counter clears on entry and increments each cycle mem_ready=0.
  - With WAIT_LIMIT≠0, when the counter reaches WAIT_LIMIT and mem_ready is still 0, the next state is HALT and fault is set.
  - mem_ready=1 in the limit cycle wins: normal progress, no fault.
- Latency with mem_ready tied high: nop 4 cycles, ALU/ldi 6, br 7, ld/st 8 (counted from F0).
- ir is sampled only in T3 and later. ir_in in F2 updates ir before T3.
- Reset in mid-instruction aborts it: outputs are 0 on the following cycle and fault is cleared.

Decomposition:
- Shared package ctrl_pkg holds the opcode constants, the state enumeration (RST, F0 to F2, T3 to T7, HALT) and the ALU_ADD/SUB/AND/OR codes.
- One sub-module, mem_wait_timer: counter plus timeout compare, with inputs clear, enable, ready and output expired.

Test Plan:
- add r3,r1,r2 (ir=0x19880000), mem_ready=1 → strobes F0,F1,F2,T3,T4,T5 as specified; T4 alu_op=0; T5 gra=1, r_in=1; back to F0 at cycle 6.
- ld r2,8(r0) with mem_ready low for 3 cycles in T6 → read and mdr_in held 4 cycles; T7 mdr_out, gra, r_in; no fault.
- br with con_ff=0 then con_ff=1 → pc_in=0 in T6 for the first, pc_in=1 with zlow_out=1 for the second.
- WAIT_LIMIT=4, mem_ready stuck 0 in F1 → HALT after 5 F1 cycles; fault=1; run=0; stays until reset.
- Opcode 11111 → HALT from T3, fault=0; reset asserted in ld-T6 → all outputs 0 the next cycle, then RST, then F0.
- sub r1,r1,r1 immediately followed by halt → the sub completes (T4 alu_op=1), then HALT with run=0.
